// File: rtl/bit_packer.sv
// rtl/bit_packer.sv - packs variable-length fields LSB-first into 32-bit words behind a small output queue
module bit_packer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pushin,
   input  logic [3:0]  lenin,
   input  logic [14:0] datain,
   input  logic        flush,
   output logic        stall,
   output logic [31:0] wordout,
   output logic [5:0]  validbits,
   output logic        wvalid,
   input  logic        wready,
   output logic        flush_done,
   output logic        ovf
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {ACC, DRAIN, PAD} state_t;

   state_t      state, state_nx;
   logic [63:0] acc, acc_nx;
   logic [6:0]  fill, fill_nx;

   logic [31:0] mem_word [DEPTH];
   logic [5:0]  mem_bits [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   count;

   logic        full, pop, enq, enq_full, pad_fire, pad_enq;
   logic [31:0] enq_word, pad_mask;
   logic [5:0]  enq_bits;
   logic [63:0] acc_base;
   logic [6:0]  fill_base;
   logic [14:0] field;
   logic        push_nz, fits, accept, drop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign pop      = wvalid && wready;
   assign enq_full = (fill >= 7'd32) && !full;

   // A full word leaves on the same edge a push lands, so the push targets the shifted accumulator.
   assign acc_base  = enq_full ? {32'd0, acc[63:32]} : acc;
   assign fill_base = enq_full ? (fill - 7'd32) : fill;
   assign field     = datain & ((15'd1 << lenin) - 15'd1);
   assign push_nz   = pushin && (lenin != 4'd0);
   assign fits      = ({1'b0, fill_base} + {4'd0, lenin}) <= 8'd64;
   assign accept    = push_nz && (state == ACC) && fits;
   assign drop      = push_nz && !accept;

   assign pad_mask = (32'd1 << fill[4:0]) - 32'd1;
   assign pad_enq  = pad_fire && (fill != 7'd0);
   assign enq      = enq_full || pad_enq;
   assign enq_word = enq_full ? acc[31:0] : (acc[31:0] & pad_mask);
   assign enq_bits = enq_full ? 6'd32 : {1'b0, fill[4:0]};

   always_comb begin
      acc_nx  = acc_base;
      fill_nx = fill_base;
      if (pad_fire) begin
         acc_nx  = '0;
         fill_nx = '0;
      end else if (accept) begin
         acc_nx  = acc_base | (64'(field) << fill_base);
         fill_nx = fill_base + {3'd0, lenin};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ACC;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ACC:     if (flush) state_nx = DRAIN;
         DRAIN:   if (fill < 7'd32) state_nx = PAD;
         PAD:     if (!full) state_nx = ACC;
         default: state_nx = ACC;
      endcase
   end

   always_comb begin
      pad_fire  = (state == PAD) && !full;
      wvalid    = (count != '0);
      stall     = (count >= (AW+1)'(DEPTH - 2)) || (fill >= 7'd48) || (state != ACC);
      wordout   = wvalid ? mem_word[rptr] : 32'd0;
      validbits = wvalid ? mem_bits[rptr] : 6'd0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc        <= '0;
         fill       <= '0;
         flush_done <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         acc        <= acc_nx;
         fill       <= fill_nx;
         flush_done <= pad_fire;
         ovf        <= ovf | drop;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (enq) wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         case ({enq, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: the count gates everything read from it.
   always_ff @(posedge clk) begin
      if (enq) begin
         mem_word[wptr] <= enq_word;
         mem_bits[wptr] <= enq_bits;
      end
   end

endmodule

// File: doc/bit_packer.md
BIT_PACKER -- requirements
Module: bit_packer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the output word queue depth (power of two, minimum 4).
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port pushin  input  1  field valid, one field per cycle.
REQ-005 SHALL have port lenin  input  4  field length in bits, 0..15.
REQ-006 SHALL have port datain  input  15  field bits, LSB-first; bits at index >= lenin are ignored.
REQ-007 SHALL have port flush  input  1  request to emit the partial word.
REQ-008 SHALL have port stall  output  1  upstream must stop issuing fields.
REQ-009 SHALL have port wordout  output  32  packed word at the queue head.
REQ-010 SHALL have port validbits  output  6  count of meaningful bits in wordout, 1..32.
REQ-011 SHALL have port wvalid  output  1  wordout/validbits valid.
REQ-012 SHALL have port wready  input  1  consumer accepts the word when wvalid and wready are both high.
REQ-013 SHALL have port flush_done  output  1  one-cycle pulse when a flush completes.
REQ-014 SHALL have port ovf  output  1  sticky error: a field was dropped.

Function
REQ-015 SHALL hold a 64-bit accumulator acc and a 7-bit fill count; a field is written at acc[fill +: lenin] with its bits masked to lenin.
REQ-016 SHALL, on an edge where fill >= 32 and the queue is not full, enqueue {acc[31:0], validbits=32}, shift acc right by 32 and subtract 32 from fill.
REQ-017 SHALL, when the enqueue of REQ-016 and an accepted push occur on the same edge, place the new field at fill-32 in the shifted acc.
REQ-018 SHALL treat a push with lenin=0 as a no-op that changes neither fill nor ovf.
REQ-019 SHALL drop a push whose resulting fill would exceed 64, leave acc and fill unchanged, and set ovf to 1 until reset.
REQ-020 SHALL drive stall high combinationally when queue count >= DEPTH-2 or fill >= 48.
REQ-021 SHALL present the queue head combinationally on wordout/validbits, with wvalid = (count != 0).
REQ-022 SHALL pop the queue on an edge where wvalid and wready are both high; a simultaneous push and pop leaves count unchanged.
REQ-023 SHALL hold the queue pointers wrapping modulo DEPTH and the count in the range 0..DEPTH.
REQ-024 SHALL give a latency of 2 edges, from the edge that makes fill >= 32 to wvalid high, when the queue is empty.
REQ-025 SHALL implement the FSM states ACC, DRAIN and PAD, with reset state ACC.
REQ-026 SHALL move from ACC to DRAIN when flush=1 is sampled; a push sampled on that same edge is included before the flush.
REQ-027 SHALL drop pushes and set ovf for each non-zero-length push sampled while the FSM is in DRAIN or PAD.
REQ-028 SHALL, in DRAIN, keep emitting full words per REQ-016 and move to PAD when fill < 32.
REQ-029 SHALL, in PAD with the queue not full:
- if fill > 0, enqueue {acc[31:0] with bits >= fill zeroed, validbits = fill}, then clear acc and fill;
- pulse flush_done on that edge;
- return to ACC.
If fill = 0 in PAD, the block SHALL enqueue nothing, pulse flush_done and return to ACC.
REQ-030 SHALL ignore flush while the FSM is in DRAIN or PAD.
REQ-031 SHALL keep stall high while the FSM is in DRAIN or PAD.

Reset
REQ-032 SHALL, while rst=1 at any time including mid-flush, force acc=0, fill=0, queue empty, FSM=ACC, ovf=0, flush_done=0, wvalid=0, wordout=0, validbits=0 and stall=0.
REQ-033 SHALL lose any words still in the queue at reset without flagging ovf.

Verification
REQ-034 SHALL cover: 8 pushes of lenin=4 with datain 1,2,...,8 and wready=1 -> one word 0x87654321 with validbits=32, wvalid high 2 edges after the 8th push.
REQ-035 SHALL cover: 3 pushes of lenin=15 with datain=0x7FFF, then flush -> word 0xFFFFFFFF/32, then word 0x00001FFF/13, then a flush_done pulse and FSM back in ACC.
REQ-036 SHALL cover: lenin=1 with datain=0x7FFE, and lenin=0 with datain=0x7FFF -> fill goes 0->1 then stays 1, the accumulated bit is 0 and ovf stays 0.
REQ-037 SHALL cover: wready=0 while streaming 16-bit pairs (two lenin=8 pushes with datain 0xAB) -> stall rises at count=DEPTH-2; continued pushes past fill 64 set ovf; after wready=1 every queued word reads 0xABABABAB.
REQ-038 SHALL cover: rst asserted asynchronously mid-clock-period while the FSM is in PAD with 2 words queued -> wvalid and stall fall immediately, no flush_done pulse, and a later push of lenin=4 with datain=5 starts a clean word.
REQ-039 SHALL cover: flush with fill=0 and the queue empty -> flush_done pulses with no word emitted.
